// File: rtl/if_stage.sv
// Instruction fetch stage: issues one outstanding imem request at a time,
// decodes the returned word into IF/ID fields, and handles stall, flush and
// branch redirect.
module if_stage (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc_if,
   output logic [31:0] pc_plus_4_if,
   output logic [6:0]  opcode_if,
   output logic [4:0]  rd_if,
   output logic [2:0]  func_3_if,
   output logic [4:0]  rs1_if,
   output logic [4:0]  rs2_if,
   output logic        func_7_bit_6_if,
   output logic [31:0] im_data_if,
   output logic        valid_if
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] buf_q;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] word_sel;
   logic            load_mem, load_buf, cap_buf, bubble;

   // State and PC registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         pc    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Next state, next PC and datapath controls; priority branch > flush > stall
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      load_mem    = 1'b0;
      load_buf    = 1'b0;
      cap_buf     = 1'b0;
      bubble      = 1'b0;
      redirect_pc = branch_target & ~XLEN'(3);
      word_sel    = buf_q;
      case (state)
         S_IDLE: begin
            state_nxt = S_REQ;
            if (branch_taken) begin
               pc_nxt = redirect_pc;
               bubble = 1'b1;
            end else if (flush) begin
               bubble = 1'b1;
            end
         end
         S_REQ: begin
            if (branch_taken) begin
               pc_nxt    = redirect_pc;
               bubble    = 1'b1;
               state_nxt = S_REQ;
            end else begin
               bubble    = flush;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (branch_taken) begin
               pc_nxt    = redirect_pc;
               bubble    = 1'b1;
               state_nxt = imem_valid ? S_REQ : S_DROP;
            end else if (imem_valid) begin
               if (flush || stall) begin
                  cap_buf   = 1'b1;
                  bubble    = flush;
                  state_nxt = S_HOLD;
               end else begin
                  load_mem  = 1'b1;
                  word_sel  = imem_rdata;
                  pc_nxt    = pc + XLEN'(4);
                  state_nxt = S_REQ;
               end
            end else begin
               bubble = flush;
            end
         end
         S_HOLD: begin
            if (branch_taken) begin
               pc_nxt    = redirect_pc;
               bubble    = 1'b1;
               state_nxt = S_REQ;
            end else if (flush) begin
               bubble = 1'b1;
            end else if (!stall) begin
               load_buf  = 1'b1;
               pc_nxt    = pc + XLEN'(4);
               state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (branch_taken) begin
               pc_nxt = redirect_pc;
               bubble = 1'b1;
            end else begin
               bubble = flush;
            end
            if (imem_valid) state_nxt = S_REQ;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // One-entry buffer for a word that arrived while the pipe was held
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          buf_q <= '0;
      else if (cap_buf) buf_q <= imem_rdata;
   end

   // Request pulse and address, registered for the cycle spent in REQ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         imem_req <= (state_nxt == S_REQ);
         if (state_nxt == S_REQ) imem_addr <= pc_nxt;
      end
   end

   // IF/ID outputs: bubble, load decoded word, or hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bubble) begin
         pc_if           <= '0;
         pc_plus_4_if    <= '0;
         opcode_if       <= NOP_WORD[6:0];
         rd_if           <= '0;
         func_3_if       <= '0;
         rs1_if          <= '0;
         rs2_if          <= '0;
         func_7_bit_6_if <= 1'b0;
         im_data_if      <= NOP_WORD;
         valid_if        <= 1'b0;
      end else if (load_mem || load_buf) begin
         pc_if           <= pc;
         pc_plus_4_if    <= pc + XLEN'(4);
         opcode_if       <= word_sel[6:0];
         rd_if           <= word_sel[11:7];
         func_3_if       <= word_sel[14:12];
         rs1_if          <= word_sel[19:15];
         rs2_if          <= word_sel[24:20];
         func_7_bit_6_if <= word_sel[30];
         im_data_if      <= word_sel;
         valid_if        <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized
// mix, checked against a transaction-level fetch model (expected PC stream
// and decoded output record).
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] pc_if, pc_plus_4_if, im_data_if;
   logic [6:0]  opcode_if;
   logic [4:0]  rd_if, rs1_if, rs2_if;
   logic [2:0]  func_3_if;
   logic        func_7_bit_6_if, valid_if;

   int total = 0;
   int bad   = 0;
   logic [31:0]  mpc;
   logic [122:0] cur_exp;

   if_stage dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc_if(pc_if), .pc_plus_4_if(pc_plus_4_if),
      .opcode_if(opcode_if), .rd_if(rd_if), .func_3_if(func_3_if),
      .rs1_if(rs1_if), .rs2_if(rs2_if), .func_7_bit_6_if(func_7_bit_6_if),
      .im_data_if(im_data_if), .valid_if(valid_if)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [122:0] obs();
      return {valid_if, pc_if, pc_plus_4_if, opcode_if, rd_if, func_3_if,
              rs1_if, rs2_if, func_7_bit_6_if, im_data_if};
   endfunction

   function automatic logic [122:0] exp_load(input logic [31:0] p, input logic [31:0] w);
      logic [31:0] p4;
      p4 = p + 32'd4;
      return {1'b1, p, p4, w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[30], w};
   endfunction

   function automatic logic [122:0] exp_bubble();
      return {1'b0, 32'd0, 32'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0013};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Wait (bounded) for a request pulse; consumes the REQ cycle
   task automatic wait_req(output bit ok, output logic [31:0] a);
      ok = 1'b0;
      a  = 'x;
      for (int i = 0; i < 20; i++) begin
         if (imem_req === 1'b1) begin
            ok = 1'b1;
            a  = imem_addr;
            step();
            return;
         end
         step();
      end
   endtask

   // Memory answers lat cycles after the request; reports whether outputs held meanwhile
   task automatic respond(input logic [31:0] w, input int lat, output bit held);
      held = 1'b1;
      for (int i = 1; i < lat; i++) begin
         step();
         if (obs() !== cur_exp || imem_req !== 1'b0) held = 1'b0;
      end
      imem_valid = 1'b1;
      imem_rdata = w;
      step();
      imem_valid = 1'b0;
      imem_rdata = $urandom;
   endtask

   task automatic test_reset();
      repeat (3) step();
      total++;
      if (obs() !== exp_bubble()) begin
         $display("FAIL reset_outputs: got %h exp %h", obs(), exp_bubble()); bad++;
      end
      total++;
      if ({imem_req, imem_addr} !== 33'd0) begin
         $display("FAIL reset_req: got %h exp 0", {imem_req, imem_addr}); bad++;
      end
      mpc = 32'd0;
      cur_exp = exp_bubble();
   endtask

   task automatic test_sequential();
      bit ok, held;
      logic [31:0] a, w;
      rst = 1'b0;
      w = 32'h0050_0093;
      for (int k = 0; k < 3; k++) begin
         wait_req(ok, a);
         total++;
         if (!ok || a !== mpc) begin
            $display("FAIL seq_addr%0d: got %h exp %h", k, a, mpc); bad++;
         end
         respond(w, 1, held);
         total++;
         if (obs() !== exp_load(mpc, w)) begin
            $display("FAIL seq_load%0d: got %h exp %h", k, obs(), exp_load(mpc, w)); bad++;
         end
         if (k == 0) begin
            total++;
            if ({pc_if, pc_plus_4_if, opcode_if, rd_if, rs1_if, valid_if} !==
                {32'h0, 32'h4, 7'h13, 5'd1, 5'd0, 1'b1}) begin
               $display("FAIL seq_first_fields: got pc=%h pc4=%h op=%h rd=%0d rs1=%0d v=%b",
                        pc_if, pc_plus_4_if, opcode_if, rd_if, rs1_if, valid_if); bad++;
            end
         end
         cur_exp = exp_load(mpc, w);
         mpc = mpc + 32'd4;
      end
   endtask

   task automatic test_stall();
      bit ok;
      logic [31:0] a, w;
      w = 32'h40B5_0533;
      wait_req(ok, a);
      total++;
      if (!ok || a !== mpc) begin
         $display("FAIL stall_addr: got %h exp %h", a, mpc); bad++;
      end
      stall = 1'b1; imem_valid = 1'b1; imem_rdata = w;
      step();
      imem_valid = 1'b0; imem_rdata = $urandom;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs() !== cur_exp || imem_req !== 1'b0) begin
            $display("FAIL stall_frozen%0d: got %h req=%b exp %h", i, obs(), imem_req, cur_exp); bad++;
         end
         if (i < 2) step();
      end
      stall = 1'b0;
      step();
      total++;
      if (obs() !== exp_load(mpc, w)) begin
         $display("FAIL stall_release: got %h exp %h", obs(), exp_load(mpc, w)); bad++;
      end
      total++;
      if ({func_7_bit_6_if, rs2_if, rs1_if, rd_if} !== {1'b1, 5'd11, 5'd10, 5'd10}) begin
         $display("FAIL stall_fields: got f7b6=%b rs2=%0d rs1=%0d rd=%0d exp 1 11 10 10",
                  func_7_bit_6_if, rs2_if, rs1_if, rd_if); bad++;
      end
      cur_exp = exp_load(mpc, w);
      mpc = mpc + 32'd4;
   endtask

   task automatic test_branch();
      bit ok, held;
      logic [31:0] a, w;
      wait_req(ok, a);
      total++;
      if (!ok || a !== mpc) begin
         $display("FAIL br_addr: got %h exp %h", a, mpc); bad++;
      end
      branch_taken = 1'b1; branch_target = 32'h0000_0103;
      step();
      branch_taken = 1'b0; branch_target = $urandom;
      total++;
      if (obs() !== exp_bubble() || imem_req !== 1'b0) begin
         $display("FAIL br_bubble: got %h req=%b exp %h", obs(), imem_req, exp_bubble()); bad++;
      end
      step();
      imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_valid = 1'b0;
      total++;
      if (obs() !== exp_bubble()) begin
         $display("FAIL br_dropped: got %h exp %h", obs(), exp_bubble()); bad++;
      end
      mpc = 32'h0000_0100;
      cur_exp = exp_bubble();
      wait_req(ok, a);
      total++;
      if (!ok || a !== mpc) begin
         $display("FAIL br_target_addr: got %h exp %h", a, mpc); bad++;
      end
      w = $urandom;
      respond(w, 2, held);
      total++;
      if (!held || obs() !== exp_load(mpc, w)) begin
         $display("FAIL br_load: held=%b got %h exp %h", held, obs(), exp_load(mpc, w)); bad++;
      end
      cur_exp = exp_load(mpc, w);
      mpc = mpc + 32'd4;
   endtask

   task automatic test_flush();
      bit ok, held;
      logic [31:0] a, w;
      wait_req(ok, a);
      total++;
      if (!ok || a !== mpc) begin
         $display("FAIL fl_addr: got %h exp %h", a, mpc); bad++;
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      total++;
      if (obs() !== exp_bubble()) begin
         $display("FAIL fl_bubble: got %h exp %h", obs(), exp_bubble()); bad++;
      end
      cur_exp = exp_bubble();
      w = $urandom;
      respond(w, 1, held);
      total++;
      if (obs() !== exp_load(mpc, w)) begin
         $display("FAIL fl_seq_load: got %h exp %h", obs(), exp_load(mpc, w)); bad++;
      end
      cur_exp = exp_load(mpc, w);
      mpc = mpc + 32'd4;
      // flush in the same cycle the word arrives: bubble first, word next
      wait_req(ok, a);
      total++;
      if (!ok || a !== mpc) begin
         $display("FAIL fl2_addr: got %h exp %h", a, mpc); bad++;
      end
      w = $urandom;
      flush = 1'b1; imem_valid = 1'b1; imem_rdata = w;
      step();
      flush = 1'b0; imem_valid = 1'b0; imem_rdata = $urandom;
      total++;
      if (obs() !== exp_bubble()) begin
         $display("FAIL fl2_bubble: got %h exp %h", obs(), exp_bubble()); bad++;
      end
      step();
      total++;
      if (obs() !== exp_load(mpc, w)) begin
         $display("FAIL fl2_buffered: got %h exp %h", obs(), exp_load(mpc, w)); bad++;
      end
      cur_exp = exp_load(mpc, w);
      mpc = mpc + 32'd4;
   endtask

   task automatic test_wrap();
      bit ok, held;
      logic [31:0] a, w;
      wait_req(ok, a);
      total++;
      if (!ok || a !== mpc) begin
         $display("FAIL wr_addr: got %h exp %h", a, mpc); bad++;
      end
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
      imem_valid = 1'b1; imem_rdata = $urandom;
      step();
      branch_taken = 1'b0; imem_valid = 1'b0;
      total++;
      if (obs() !== exp_bubble()) begin
         $display("FAIL wr_bubble: got %h exp %h", obs(), exp_bubble()); bad++;
      end
      mpc = 32'hFFFF_FFFC;
      cur_exp = exp_bubble();
      wait_req(ok, a);
      total++;
      if (!ok || a !== mpc) begin
         $display("FAIL wr_target_addr: got %h exp %h", a, mpc); bad++;
      end
      w = $urandom;
      respond(w, 1, held);
      total++;
      if (obs() !== exp_load(mpc, w) || pc_plus_4_if !== 32'h0) begin
         $display("FAIL wr_load: got %h exp %h", obs(), exp_load(mpc, w)); bad++;
      end
      cur_exp = exp_load(mpc, w);
      mpc = mpc + 32'd4;
   endtask

   task automatic test_reset_mid_wait();
      bit ok, held;
      logic [31:0] a, w;
      wait_req(ok, a);
      total++;
      if (!ok || a !== mpc) begin
         $display("FAIL rw_wrap_addr: got %h exp %h", a, mpc); bad++;
      end
      rst = 1'b1;
      #1;
      total++;
      if (obs() !== exp_bubble() || {imem_req, imem_addr} !== 33'd0) begin
         $display("FAIL rw_async: got %h req=%b addr=%h", obs(), imem_req, imem_addr); bad++;
      end
      step();
      rst = 1'b0;
      imem_valid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
      step();
      imem_valid = 1'b0;
      total++;
      if (obs() !== exp_bubble()) begin
         $display("FAIL rw_stale_ignored: got %h exp %h", obs(), exp_bubble()); bad++;
      end
      mpc = 32'd0;
      cur_exp = exp_bubble();
      wait_req(ok, a);
      total++;
      if (!ok || a !== 32'd0) begin
         $display("FAIL rw_first_addr: got %h exp 0", a); bad++;
      end
      w = $urandom;
      respond(w, 3, held);
      total++;
      if (!held || obs() !== exp_load(mpc, w)) begin
         $display("FAIL rw_load: held=%b got %h exp %h", held, obs(), exp_load(mpc, w)); bad++;
      end
      cur_exp = exp_load(mpc, w);
      mpc = mpc + 32'd4;
   endtask

   task automatic test_random();
      bit ok, held, frz;
      logic [31:0] a, w, tgt;
      int kind, lat, n;
      for (int it = 0; it < 60; it++) begin
         wait_req(ok, a);
         total++;
         if (!ok || a !== mpc) begin
            $display("FAIL rnd_addr%0d: got %h exp %h", it, a, mpc); bad++;
         end
         kind = $urandom_range(0, 4);
         w = $urandom;
         lat = $urandom_range(1, 3);
         case (kind)
            0, 2: begin
               if (kind == 2) begin
                  flush = 1'b1; step(); flush = 1'b0;
                  cur_exp = exp_bubble();
               end
               respond(w, lat, held);
               total++;
               if (!held || obs() !== exp_load(mpc, w)) begin
                  $display("FAIL rnd_load%0d: held=%b got %h exp %h", it, held, obs(), exp_load(mpc, w)); bad++;
               end
               cur_exp = exp_load(mpc, w);
               mpc = mpc + 32'd4;
            end
            1: begin
               stall = 1'b1; imem_valid = 1'b1; imem_rdata = w;
               step();
               imem_valid = 1'b0; imem_rdata = $urandom;
               frz = 1'b1;
               n = $urandom_range(0, 3);
               for (int i = 0; i < n; i++) begin
                  if (obs() !== cur_exp || imem_req !== 1'b0) frz = 1'b0;
                  step();
               end
               if (obs() !== cur_exp || imem_req !== 1'b0) frz = 1'b0;
               stall = 1'b0;
               step();
               total++;
               if (!frz || obs() !== exp_load(mpc, w)) begin
                  $display("FAIL rnd_stall%0d: frozen=%b got %h exp %h", it, frz, obs(), exp_load(mpc, w)); bad++;
               end
               cur_exp = exp_load(mpc, w);
               mpc = mpc + 32'd4;
            end
            default: begin
               tgt = $urandom;
               branch_taken = 1'b1; branch_target = tgt;
               imem_valid = (kind == 4); imem_rdata = $urandom;
               step();
               branch_taken = 1'b0; imem_valid = 1'b0;
               total++;
               if (obs() !== exp_bubble()) begin
                  $display("FAIL rnd_branch%0d: got %h exp %h", it, obs(), exp_bubble()); bad++;
               end
               if (kind == 3) begin
                  n = $urandom_range(0, 2);
                  repeat (n) step();
                  imem_valid = 1'b1; imem_rdata = $urandom;
                  step();
                  imem_valid = 1'b0;
               end
               mpc = {tgt[31:2], 2'b00};
               cur_exp = exp_bubble();
            end
         endcase
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_flush();
      test_wrap();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
